seq_wide_adder: RTL and testbench
=================================

Name: seq_wide_adder

Overview:
- Multi-cycle controller that computes a WORDS×16-bit add or subtract on a single shared 16-bit carry-chain slice.
- Processes one 16-bit word per cycle, least-significant word first, and carries the borrow/carry between cycles in a register.
- Sits between the issue logic and the register file. Gives 32/64-bit arithmetic without widening the adder.
- Ready/valid handshake on both the command side and the result side.

Parameters:
- WORDS, 4, number of 16-bit words per operand (≥2). Operand width is 16*WORDS.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command (high only in IDLE).
- cmd_sub  in  1  0 = A+B, 1 = A−B.
- cmd_a  in  16*WORDS  operand A.
- cmd_b  in  16*WORDS  operand B.
- res_valid  out  1  result and flags valid.
- res_ready  in  1  consumer accepts the result.
- res_sum  out  16*WORDS  result.
- res_ov  out  1  signed overflow.
- res_zf  out  1  result == 0.
- res_nf  out  1  result MSB.
- res_cf  out  1  carry out of the top word.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values: state IDLE, cmd_ready=1, res_valid=0, res_sum=0, all flags 0, word index 0, carry register 0.
- FSM IDLE→RUN: on cmd_valid & cmd_ready.
  - Capture cmd_a, cmd_b, cmd_sub into internal registers. Inputs may change afterwards.
  - Carry register ← cmd_sub. Index ← 0. Zero accumulator ← 1.
- FSM RUN, each cycle at index i:
  - Slice inputs: a_w=A[16i+15:16i]; b_w=B word, inverted when sub; cin=carry register.
  - Register updates: sum word i ← slice sum; carry ← slice carry-out; zero accumulator &= (slice sum==0).
  - At i=WORDS−1: latch OV = carry into bit 15 XOR carry out of bit 15. Latch CF = final carry out.
  - At i=WORDS−1, go to DONE; otherwise i←i+1.
- FSM DONE:
  - res_valid=1.
  - res_zf = zero accumulator; res_nf = res_sum MSB.
  - DONE→IDLE on res_ready. res_valid drops the next cycle.
- Latency: accept edge at cycle 0 → res_valid high after exactly WORDS+1 rising edges. Throughput is one op per WORDS+2 cycles minimum (no overlap of DONE with the next accept).
- Backpressure: in DONE with res_ready=0, res_sum and flags are held stable and cmd_ready stays 0.
- Subtract CF: raw carry (1 = no borrow). It is not inverted.
- Intermediate visibility: res_sum words are visible mid-RUN but are meaningful only while res_valid=1. Flags update only on the final RUN cycle.
- Reset mid-operation: any state returns to IDLE immediately. All outputs go to reset values. The in-flight command is discarded with no result.
- cmd_valid while not IDLE: ignored, and not queued.

Optional Feature:
- Macro: SEQ_WIDE_ADDER_SAT_EN.
- With the macro defined: if OV=1 at the final word, res_sum is forced to signed saturation.
  - 0x7FFF…F when A's MSB=0.
  - 0x8000…0 when A's MSB=1.
  - res_ov still reports 1. res_zf and res_nf reflect the saturated value.
  - res_cf is unchanged.
- Without the macro: res_sum is the wrapped two's-complement result. No saturation logic is compiled in.

Decomposition:
- Package seq_wide_adder_pkg:
  - state enum IDLE/RUN/DONE;
  - SLICE_W=16;
  - SAT_POS/SAT_NEG helper constants parameterised by width.
- Sub-module add16_slice: purely combinational 16-bit carry-lookahead slice.
  - Inputs a, b, cin.
  - Outputs sum, cout, c15 (carry into bit 15).
  - The controller instantiates it once and owns all sequencing, registers and flags.

Test Plan (WORDS=4):
- add 0x0000_0000_0000_FFFF + 0x1 → res_sum 0x0000_0000_0001_0000, OV=0 ZF=0 NF=0 CF=0; res_valid exactly 5 edges after accept.
- add 0x7FFF_FFFF_FFFF_FFFF + 0x1:
  - without the macro → 0x8000_0000_0000_0000, OV=1 NF=1 CF=0;
  - with SEQ_WIDE_ADDER_SAT_EN → 0x7FFF_FFFF_FFFF_FFFF, OV=1 NF=0.
- sub 0x5 − 0x5 → res_sum 0, ZF=1 CF=1 OV=0 NF=0.
- sub 0x0 − 0x1 → res_sum 0xFFFF_FFFF_FFFF_FFFF, NF=1 CF=0 OV=0 ZF=0. Then add 0xFFFF_FFFF_FFFF_FFFF + 0x1 → 0, ZF=1 CF=1.
- Backpressure: hold res_ready=0 for 10 cycles with cmd_valid=1 → res_sum and flags stable, cmd_ready=0, no second accept; after res_ready pulse, cmd_ready=1 the next cycle.
- Assert rst mid-RUN at index 2 → all outputs 0 and cmd_ready=1 immediately. After release, 0x1_0000_0000 + 0xFFFF_FFFF → 0x1_FFFF_FFFF, correct.

Source files
------------

// File: rtl/seq_wide_adder_pkg.sv
// seq_wide_adder_pkg: shared types, slice width and saturation constants for seq_wide_adder
package seq_wide_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int SLICE_W = 16;
  localparam int MAX_W = 1024;
  function automatic logic [MAX_W-1:0] sat_pos(input int w);
    return {MAX_W{1'b1}} >> (MAX_W - w + 1);
  endfunction
  function automatic logic [MAX_W-1:0] sat_neg(input int w);
    return {{(MAX_W-1){1'b0}}, 1'b1} << (w - 1);
  endfunction
endpackage

// File: rtl/seq_wide_adder_slice.sv
// add16_slice: combinational 16-bit parallel-prefix carry-lookahead adder slice
module add16_slice
  import seq_wide_adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout,
  output logic               c15
);
  logic [SLICE_W-1:0] w_g, w_p;
  logic [SLICE_W:0]   w_c;
  // Kogge-Stone prefix; descending index keeps lower bits at their previous-level values
  always_comb begin
    w_g = a & b;
    w_p = a ^ b;
    for (int d = 1; d < SLICE_W; d *= 2)
      for (int i = SLICE_W - 1; i >= d; i--) begin
        w_g[i] = w_g[i] | (w_p[i] & w_g[i-d]);
        w_p[i] = w_p[i] & w_p[i-d];
      end
    w_c = {w_g | (w_p & {SLICE_W{cin}}), cin};
  end
  assign sum  = a ^ b ^ w_c[SLICE_W-1:0];
  assign cout = w_c[SLICE_W];
  assign c15  = w_c[SLICE_W-1];
endmodule

// File: rtl/seq_wide_adder.sv
// seq_wide_adder: WORDS x 16-bit add/sub over one shared slice, one word per cycle, LSW first.
// Define SEQ_WIDE_ADDER_SAT_EN to saturate the result on signed overflow.
module seq_wide_adder
  import seq_wide_adder_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_sub,
  input  logic [SLICE_W*WORDS-1:0]   cmd_a,
  input  logic [SLICE_W*WORDS-1:0]   cmd_b,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [SLICE_W*WORDS-1:0]   res_sum,
  output logic                       res_ov,
  output logic                       res_zf,
  output logic                       res_nf,
  output logic                       res_cf
);
  localparam int W  = SLICE_W * WORDS;
  localparam int IW = $clog2(WORDS);
`ifdef SEQ_WIDE_ADDER_SAT_EN
  localparam logic [W-1:0] SAT_POS = W'(sat_pos(W));
  localparam logic [W-1:0] SAT_NEG = W'(sat_neg(W));
`endif
  state_t             r_state;
  logic [W-1:0]       r_a, r_b, r_sum;
  logic               r_sub, r_carry, r_zacc, r_ov, r_zf, r_nf, r_cf;
  logic [IW-1:0]      r_idx;
  logic [SLICE_W-1:0] w_b, w_sum;
  logic               w_cout, w_c15, w_last, w_zacc, w_ov;
  assign w_b    = r_sub ? ~r_b[r_idx*SLICE_W +: SLICE_W] : r_b[r_idx*SLICE_W +: SLICE_W];
  assign w_last = r_idx == IW'(WORDS - 1);
  assign w_zacc = r_zacc & (w_sum == '0);
  assign w_ov   = w_c15 ^ w_cout;
  add16_slice u_slice (
    .a    (r_a[r_idx*SLICE_W +: SLICE_W]),
    .b    (w_b),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout),
    .c15  (w_c15)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_zacc  <= 1'b0;
      r_idx   <= '0;
      r_ov    <= 1'b0;
      r_zf    <= 1'b0;
      r_nf    <= 1'b0;
      r_cf    <= 1'b0;
    end else if (r_state == IDLE) begin
      if (cmd_valid) begin
        r_a     <= cmd_a;
        r_b     <= cmd_b;
        r_sub   <= cmd_sub;
        r_carry <= cmd_sub;
        r_idx   <= '0;
        r_zacc  <= 1'b1;
        r_state <= RUN;
      end
    end else if (r_state == RUN) begin
      r_sum[r_idx*SLICE_W +: SLICE_W] <= w_sum;
      r_carry <= w_cout;
      r_zacc  <= w_zacc;
      if (w_last) begin
        r_ov    <= w_ov;
        r_cf    <= w_cout;
        r_zf    <= w_zacc;
        r_nf    <= w_sum[SLICE_W-1];
`ifdef SEQ_WIDE_ADDER_SAT_EN
        if (w_ov) begin
          r_sum <= r_a[W-1] ? SAT_NEG : SAT_POS;
          r_zf  <= 1'b0;
          r_nf  <= r_a[W-1];
        end
`endif
        r_state <= DONE;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end else if (res_ready) begin
      r_state <= IDLE;
    end
  end
  assign cmd_ready = r_state == IDLE;
  assign res_valid = r_state == DONE;
  assign res_sum   = r_sum;
  assign res_ov    = r_ov;
  assign res_zf    = r_zf;
  assign res_nf    = r_nf;
  assign res_cf    = r_cf;
endmodule

// File: tb/tb_seq_wide_adder.sv
// tb_seq_wide_adder: directed vectors plus an arithmetic scoreboard for seq_wide_adder (WORDS=4)
module tb_seq_wide_adder;
  logic        clk = 0, rst = 1;
  logic        cmd_valid = 0, cmd_sub = 0, res_ready = 0;
  logic [63:0] cmd_a = '0, cmd_b = '0;
  logic        cmd_ready, res_valid, res_ov, res_zf, res_nf, res_cf;
  logic [63:0] res_sum;
  int n_pass = 0, n_chk = 0;

  typedef struct packed {logic [63:0] sum; logic [3:0] fl;} res_t;
  res_t q[$];

  seq_wide_adder #(.WORDS(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sub(cmd_sub),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_ov(res_ov), .res_zf(res_zf), .res_nf(res_nf), .res_cf(res_cf)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Signed overflow from the exact 65-bit two's-complement result
  function automatic res_t model(input logic [63:0] a, input logic [63:0] b, input logic s);
    res_t r;
    logic [64:0] u;
    logic signed [65:0] t;
    logic ov;
    u = s ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
    t = s ? $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b})
          : $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
    ov = (t > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (t < -66'sh0_8000_0000_0000_0000);
    r.sum = u[63:0];
`ifdef SEQ_WIDE_ADDER_SAT_EN
    if (ov) r.sum = a[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`endif
    r.fl = {ov, r.sum == 64'h0, r.sum[63], s ? ~u[64] : u[64]};
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) q.delete();
    else begin
      if (res_valid) begin
        if (q.size() == 0) check("sb_spurious_valid", 64'(res_valid), 64'(1'b0));
        else begin
          check("sb_sum", res_sum, q[0].sum);
          check("sb_flags", 64'({res_ov, res_zf, res_nf, res_cf}), 64'(q[0].fl));
          if (res_ready) void'(q.pop_front());
        end
      end
      if (cmd_valid && cmd_ready) q.push_back(model(cmd_a, cmd_b, cmd_sub));
    end
  end

  task automatic accept_cmd(input string nm, input logic [63:0] a, input logic [63:0] b, input logic s);
    bit acc = 0;
    cmd_a = a; cmd_b = b; cmd_sub = s; cmd_valid = 1;
    for (int t = 0; t < 20 && !acc; t++) begin
      acc = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 0; cmd_a = {$urandom, $urandom}; cmd_b = {$urandom, $urandom}; cmd_sub = ~s;
    check({nm, "_accept"}, 64'(acc), 64'(1'b1));
  endtask

  task automatic issue(input string nm, input logic [63:0] a, input logic [63:0] b, input logic s);
    int lat = 1;
    accept_cmd(nm, a, b, s);
    while (!res_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, 64'(lat), 64'(5));
  endtask

  task automatic finish_op(input string nm, input logic [63:0] es, input logic [3:0] ef);
    check({nm, "_sum"}, res_sum, es);
    check({nm, "_flags"}, 64'({res_ov, res_zf, res_nf, res_cf}), 64'(ef));
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
    check({nm, "_release"}, 64'({res_valid, cmd_ready}), 64'(2'b01));
  endtask

  task automatic run_op(input string nm, input logic [63:0] a, input logic [63:0] b, input logic s,
                        input logic [63:0] es, input logic [3:0] ef);
    issue(nm, a, b, s);
    finish_op(nm, es, ef);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #2;
    check("reset_outs", 64'({cmd_ready, res_valid, res_ov, res_zf, res_nf, res_cf}), 64'(6'b100000));
    check("reset_sum", res_sum, 64'h0);
    @(posedge clk); #1 rst = 0;
    run_op("add_carry16", 64'h0000_0000_0000_FFFF, 64'h1, 0, 64'h0000_0000_0001_0000, 4'b0000);
`ifdef SEQ_WIDE_ADDER_SAT_EN
    run_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b1000);
    run_op("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1, 64'h8000_0000_0000_0000, 4'b1011);
`else
    run_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 0, 64'h8000_0000_0000_0000, 4'b1010);
    run_op("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b1001);
`endif
    run_op("sub_eq", 64'h5, 64'h5, 1, 64'h0, 4'b0101);
    run_op("sub_borrow", 64'h0, 64'h1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010);
    run_op("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 64'h0, 4'b0101);
    issue("bp", 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 0);
    cmd_valid = 1; cmd_a = 64'h1; cmd_b = 64'h1;
    for (int i = 0; i < 10; i++) begin
      check("bp_sum", res_sum, 64'h2345_6789_ABCD_F001);
      check("bp_hs", 64'({res_valid, cmd_ready, res_ov, res_zf, res_nf, res_cf}), 64'(6'b100000));
      @(posedge clk); #1;
    end
    cmd_valid = 0;
    finish_op("bp", 64'h2345_6789_ABCD_F001, 4'b0000);
    accept_cmd("rst_mid", 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1;
    #1;
    check("rst_mid_outs", 64'({cmd_ready, res_valid, res_ov, res_zf, res_nf, res_cf}), 64'(6'b100000));
    check("rst_mid_sum", res_sum, 64'h0);
    @(posedge clk); #1 rst = 0;
    for (int i = 0; i < 6; i++) begin
      check("rst_discard", 64'({res_valid, cmd_ready}), 64'(2'b01));
      @(posedge clk); #1;
    end
    run_op("post_rst", 64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 0, 64'h0000_0001_FFFF_FFFF, 4'b0000);
    repeat (3) @(posedge clk);
    check("sb_drained", 64'(q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
